// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous SRAM between an instruction-fetch read port
// and a data-memory read/write port, with bounded starvation of the fetch side.
module mem_arbiter #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [3:0]        sram_w_en,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    logic [3:0] streak_q;
    logic [3:0] streak_d;
    owner_e     rd_owner_q;
    owner_e     rd_owner_d;
    logic       grant_if;
    logic       grant_dm;

    // DM wins contention until it has taken STREAK_MAX grants in a row over a waiting fetch.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (!rst) begin
            if (if_req && dm_req) begin
                if (streak_q == STREAK_MAX) begin
                    grant_if = 1'b1;
                end else begin
                    grant_dm = 1'b1;
                end
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (dm_req) begin
                grant_dm = 1'b1;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (grant_if || !if_req) begin
            streak_d = '0;
        end else if (grant_dm && (streak_q < STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Writes complete at the granting edge, so only reads claim the return slot.
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (grant_if) begin
            rd_owner_d = OWN_IF;
        end else if (grant_dm && (dm_we == 4'b0000)) begin
            rd_owner_d = OWN_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q   <= '0;
            rd_owner_q <= OWN_NONE;
        end else begin
            streak_q   <= streak_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        sram_addr  = '0;
        sram_w_en  = 4'b0000;
        sram_wdata = '0;
        if (grant_if) begin
            sram_addr = if_addr;
        end else if (grant_dm) begin
            sram_addr  = dm_addr;
            sram_w_en  = dm_we;
            sram_wdata = dm_wdata;
        end
    end

    assign if_gnt    = grant_if;
    assign dm_gnt    = grant_dm;
    assign if_stall  = if_req & ~grant_if;
    assign dm_stall  = dm_req & ~grant_dm;
    assign if_rvalid = (rd_owner_q == OWN_IF);
    assign dm_rvalid = (rd_owner_q == OWN_DM);
    assign if_rdata  = sram_rdata;
    assign dm_rdata  = sram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural SRAM plus a read-return scoreboard keyed by due cycle.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [15:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_stall;
    logic [15:0] sram_addr;
    logic [3:0]  sram_w_en;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic sb_en  = 1'b0;

    typedef struct {
        int          due;
        logic        is_if;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    logic exp_if;
    logic exp_dm;
    logic [31:0] exp_data;

    logic [31:0] mem [0:65535];

    mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(32),
        .MAX_DM_STREAK(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .if_stall(if_stall),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata),
        .dm_stall(dm_stall),
        .sram_addr(sram_addr),
        .sram_w_en(sram_w_en),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: 1-cycle read latency, read-before-write, contents loaded while in reset.
    always @(posedge clk) begin
        sram_rdata <= mem[sram_addr];
        if (rst) begin
            mem[16'h0000] <= 32'h0000_0011;
            mem[16'h0004] <= 32'h0000_0022;
            mem[16'h0008] <= 32'h0000_0033;
            mem[16'h0010] <= 32'h1234_5678;
            mem[16'h0020] <= 32'hDEAD_0001;
            mem[16'h0024] <= 32'h00C0_FFEE;
            mem[16'h0100] <= 32'h0100_0100;
            mem[16'h0200] <= 32'h0200_0200;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (sram_w_en[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    // Read-return scoreboard: each granted read is due exactly one cycle after its grant.
    always @(negedge clk) begin
        if (sb_en) begin
            exp_if   = 1'b0;
            exp_dm   = 1'b0;
            exp_data = '0;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                sb_e     = sb_q.pop_front();
                exp_if   = sb_e.is_if;
                exp_dm   = !sb_e.is_if;
                exp_data = sb_e.data;
            end
            checks++;
            if (if_rvalid !== exp_if) begin
                failures++;
                $display("FAIL sb_if_rvalid cyc=%0d: got %b expected %b", cyc, if_rvalid, exp_if);
            end
            checks++;
            if (dm_rvalid !== exp_dm) begin
                failures++;
                $display("FAIL sb_dm_rvalid cyc=%0d: got %b expected %b", cyc, dm_rvalid, exp_dm);
            end
            if (exp_if) begin
                checks++;
                if (if_rdata !== exp_data) begin
                    failures++;
                    $display("FAIL sb_if_rdata cyc=%0d: got %h expected %h", cyc, if_rdata, exp_data);
                end
            end
            if (exp_dm) begin
                checks++;
                if (dm_rdata !== exp_data) begin
                    failures++;
                    $display("FAIL sb_dm_rdata cyc=%0d: got %h expected %h", cyc, dm_rdata, exp_data);
                end
            end
        end
    end

    function automatic void sb_push(input logic is_if, input logic [31:0] data);
        exp_t e;
        e.due   = cyc + 1;
        e.is_if = is_if;
        e.data  = data;
        sb_q.push_back(e);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if_req = 1'b0;
            dm_req = 1'b0;
            dm_we  = 4'b0000;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 4'b0000;
        if_addr = 16'h0024; dm_addr = 16'h0020; dm_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            sb_en = 1'b1;
            @(negedge clk);
            checks++;
            if (if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin
                failures++;
                $display("FAIL reset_gnt: got if=%b dm=%b expected 0 0", if_gnt, dm_gnt);
            end
            checks++;
            if (sram_w_en !== 4'b0000 || sram_addr !== 16'h0000) begin
                failures++;
                $display("FAIL reset_sram: got w_en=%b addr=%h expected 0 0", sram_w_en, sram_addr);
            end
            checks++;
            if (if_stall !== 1'b1 || dm_stall !== 1'b1) begin
                failures++;
                $display("FAIL reset_stall: got if=%b dm=%b expected 1 1", if_stall, dm_stall);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant: got if=%b dm=%b expected 0 1", if_gnt, dm_gnt);
        end
        if (dm_gnt === 1'b1) sb_push(1'b0, 32'hDEAD_0001);
        idle(2);
    endtask

    task automatic test_if_only();
        logic [15:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{16'h0000, 16'h0004, 16'h0008};
        datas = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = addrs[i]; dm_req = 1'b0;
            @(negedge clk);
            checks++;
            if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || if_stall !== 1'b0) begin
                failures++;
                $display("FAIL if_only_gnt[%0d]: got gnt=%b stall=%b expected 1 0", i, if_gnt, if_stall);
            end
            checks++;
            if (sram_addr !== addrs[i] || sram_w_en !== 4'b0000) begin
                failures++;
                $display("FAIL if_only_sram[%0d]: got addr=%h w_en=%b expected %h 0", i, sram_addr, sram_w_en, addrs[i]);
            end
            if (if_gnt === 1'b1) sb_push(1'b1, datas[i]);
        end
        idle(2);
    endtask

    task automatic test_contention();
        logic [9:0] pat;
        int if_stalls;
        int dm_stalls;
        pat = 10'b10_0001_0000;
        if_stalls = 0;
        dm_stalls = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = 16'h0100;
            dm_req = 1'b1; dm_addr = 16'h0200; dm_we = 4'b0000;
            @(negedge clk);
            checks++;
            if (if_gnt !== pat[i] || dm_gnt !== !pat[i]) begin
                failures++;
                $display("FAIL contention_gnt[%0d]: got if=%b dm=%b expected %b %b", i, if_gnt, dm_gnt, pat[i], !pat[i]);
            end
            if (if_stall === 1'b1) if_stalls++;
            if (dm_stall === 1'b1) dm_stalls++;
            if (if_gnt === 1'b1) sb_push(1'b1, 32'h0100_0100);
            else if (dm_gnt === 1'b1) sb_push(1'b0, 32'h0200_0200);
        end
        checks++;
        if (if_stalls != 8 || dm_stalls != 2) begin
            failures++;
            $display("FAIL contention_stalls: got if=%0d dm=%0d expected 8 2", if_stalls, dm_stalls);
        end
        idle(2);
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        if_req = 1'b0;
        dm_req = 1'b1; dm_we = 4'b0011; dm_addr = 16'h0010; dm_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1'b1 || sram_w_en !== 4'b0011 || sram_wdata !== 32'hAABB_CCDD || sram_addr !== 16'h0010) begin
            failures++;
            $display("FAIL write_drive: got gnt=%b w_en=%b wdata=%h addr=%h expected 1 0011 aabbccdd 0010",
                     dm_gnt, sram_w_en, sram_wdata, sram_addr);
        end
        @(posedge clk); #1;
        dm_we = 4'b0000; dm_wdata = '0;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1'b1 || sram_w_en !== 4'b0000) begin
            failures++;
            $display("FAIL read_after_write_gnt: got gnt=%b w_en=%b expected 1 0", dm_gnt, sram_w_en);
        end
        if (dm_gnt === 1'b1) sb_push(1'b0, 32'h1234_CCDD);
        idle(2);
    endtask

    task automatic test_interleave();
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b1; dm_we = 4'b0000; dm_addr = 16'h0020;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            failures++;
            $display("FAIL interleave_dm_gnt: got if=%b dm=%b expected 0 1", if_gnt, dm_gnt);
        end
        if (dm_gnt === 1'b1) sb_push(1'b0, 32'hDEAD_0001);
        @(posedge clk); #1;
        dm_req = 1'b0; if_req = 1'b1; if_addr = 16'h0024;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1 || dm_gnt !== 1'b0) begin
            failures++;
            $display("FAIL interleave_if_gnt: got if=%b dm=%b expected 1 0", if_gnt, dm_gnt);
        end
        if (if_gnt === 1'b1) sb_push(1'b1, 32'h00C0_FFEE);
        idle(2);
    endtask

    task automatic test_reset_mid_read();
        // Build a full streak so a surviving streak would hand the next contended grant to IF.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if_req = 1'b1; if_addr = 16'h0100;
            dm_req = 1'b1; dm_addr = 16'h0200; dm_we = 4'b0000;
            @(negedge clk);
            checks++;
            if (dm_gnt !== 1'b1) begin
                failures++;
                $display("FAIL midrst_streak[%0d]: got dm_gnt=%b expected 1", i, dm_gnt);
            end
            if (dm_gnt === 1'b1) sb_push(1'b0, 32'h0200_0200);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || if_stall !== 1'b1 || dm_stall !== 1'b1) begin
            failures++;
            $display("FAIL midrst_in_reset: got gnt=%b%b stall=%b%b expected 00 11", if_gnt, dm_gnt, if_stall, dm_stall);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
            failures++;
            $display("FAIL midrst_streak_cleared: got if=%b dm=%b expected 0 1", if_gnt, dm_gnt);
        end
        if (dm_gnt === 1'b1) sb_push(1'b0, 32'h0200_0200);
        // IF request arriving in the reset cycle must never produce a return.
        @(posedge clk); #1;
        rst = 1'b1; dm_req = 1'b0; if_req = 1'b1; if_addr = 16'h0024;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b0 || sram_addr !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_if_gnt: got gnt=%b addr=%h expected 0 0000", if_gnt, sram_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        idle(2);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = '0; dm_addr = '0; dm_wdata = '0;
        test_reset();
        test_if_only();
        test_contention();
        test_write_read();
        test_interleave();
        test_reset_mid_read();
        sb_en = 1'b0;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending reads expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
